// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2 outer-loop controller: password FIFO, HMAC request sequencing and T = U1^..^Uc accumulation.
// Define PBKDF2_PIM_EN to treat i_iter as a PIM value (c = 15000 + 1000*PIM, 0 -> DEFAULT_ITER).
//
// state | meaning
// IDLE  | waiting for a queued password
// LOAD  | pop password, latch salt and iteration count, clear T
// CALC  | PIM builds only: register the PIM-derived iteration count
// ISSUE | HMAC request valid, waiting for i_hmac_ready
// WAIT  | waiting for the HMAC done pulse
// OUT   | derived key valid, waiting for i_key_ready
module pbkdf2_iter_ctrl #(
  parameter int PASS_W       = 192,
  parameter int SALT_W       = 512,
  parameter int HASH_W       = 512,
  parameter int ITER_W       = 19,
  parameter int FIFO_DEPTH   = 4,
  parameter int DEFAULT_ITER = 500000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pass_valid,
  output logic              o_pass_ready,
  input  logic [PASS_W-1:0] i_pass,
  input  logic [SALT_W-1:0] i_salt,
  input  logic [ITER_W-1:0] i_iter,
  output logic              o_hmac_valid,
  input  logic              i_hmac_ready,
  output logic              o_hmac_first,
  output logic [PASS_W-1:0] o_hmac_key,
  output logic [SALT_W-1:0] o_hmac_salt,
  output logic [HASH_W-1:0] o_hmac_msg,
  input  logic              i_hmac_done,
  input  logic [HASH_W-1:0] i_hmac_digest,
  output logic              o_key_valid,
  input  logic              i_key_ready,
  output logic [HASH_W-1:0] o_key,
  output logic [PASS_W-1:0] o_pass,
  output logic [ITER_W-1:0] o_loop,
  output logic              o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_ISSUE, S_WAIT, S_OUT} state_t;

  logic [PASS_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              ready_q, push, pop;

  state_t            state_q;
  logic [PASS_W-1:0] pass_q;
  logic [SALT_W-1:0] salt_q;
  logic [HASH_W-1:0] t_q, u_q;
  logic [ITER_W-1:0] c_q, loop_q, loop_next, iter_raw, iter_c;
  logic              hmac_valid_q, first_q, key_valid_q, busy_q;

  assign push    = i_pass_valid && ready_q;
  assign pop     = (state_q == S_LOAD);
  assign count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_pass;
  end

  // Ready is registered from the next count, so a push against a full FIFO is refused even when a pop coincides.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d != (PTR_W+1)'(FIFO_DEPTH));
    end
  end

`ifdef PBKDF2_PIM_EN
  localparam int CW = ITER_W + 12;
  localparam logic [CW-1:0] ITER_MAX_W = {{12{1'b0}}, {ITER_W{1'b1}}};
  logic [ITER_W-1:0] pim_q;
  logic [CW-1:0]     pim_calc;
  assign pim_calc = (pim_q == '0) ? CW'(DEFAULT_ITER) : CW'(15000) + CW'(pim_q) * CW'(1000);
  assign iter_raw = (pim_calc > ITER_MAX_W) ? {ITER_W{1'b1}} : pim_calc[ITER_W-1:0];
`else
  assign iter_raw = i_iter;
`endif
  assign iter_c    = (iter_raw == '0) ? ITER_W'(1) : iter_raw;
  assign loop_next = loop_q + ITER_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      pass_q       <= '0;
      salt_q       <= '0;
      t_q          <= '0;
      u_q          <= '0;
      c_q          <= '0;
      loop_q       <= '0;
      hmac_valid_q <= 1'b0;
      first_q      <= 1'b0;
      key_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PBKDF2_PIM_EN
      pim_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          pass_q <= mem_q[rd_ptr_q];
          salt_q <= i_salt;
          t_q    <= '0;
          u_q    <= '0;
          loop_q <= '0;
`ifdef PBKDF2_PIM_EN
          pim_q   <= i_iter;
          state_q <= S_CALC;
`else
          c_q          <= iter_c;
          state_q      <= S_ISSUE;
          hmac_valid_q <= 1'b1;
          first_q      <= 1'b1;
`endif
        end
`ifdef PBKDF2_PIM_EN
        S_CALC: begin
          c_q          <= iter_c;
          state_q      <= S_ISSUE;
          hmac_valid_q <= 1'b1;
          first_q      <= 1'b1;
        end
`endif
        S_ISSUE: begin
          if (i_hmac_ready) begin
            hmac_valid_q <= 1'b0;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_hmac_done) begin
            t_q    <= t_q ^ i_hmac_digest;
            u_q    <= i_hmac_digest;
            loop_q <= loop_next;
            if (loop_next == c_q) begin
              state_q     <= S_OUT;
              key_valid_q <= 1'b1;
            end else begin
              state_q      <= S_ISSUE;
              hmac_valid_q <= 1'b1;
              first_q      <= 1'b0;
            end
          end
        end
        S_OUT: begin
          if (i_key_ready) begin
            key_valid_q <= 1'b0;
            if (count_q != '0) begin
              state_q <= S_LOAD;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_pass_ready = ready_q;
  assign o_hmac_valid = hmac_valid_q;
  assign o_hmac_first = first_q;
  assign o_hmac_key   = pass_q;
  assign o_hmac_salt  = salt_q;
  assign o_hmac_msg   = u_q;
  assign o_key_valid  = key_valid_q;
  assign o_key        = t_q;
  assign o_pass       = pass_q;
  assign o_loop       = loop_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// Randomised bench for pbkdf2_iter_ctrl: an HMAC responder plus a job-level model of T, U, loop count and password order.
module tb_pbkdf2_iter_ctrl;
  localparam int PASS_W = 192, SALT_W = 512, HASH_W = 512, ITER_W = 19;
  localparam int FIFO_DEPTH = 4, DEFAULT_ITER = 500000;

  logic              i_clk = 1'b0;
  logic              i_rst, i_pass_valid, i_hmac_ready, i_hmac_done, i_key_ready;
  logic [PASS_W-1:0] i_pass;
  logic [SALT_W-1:0] i_salt;
  logic [ITER_W-1:0] i_iter;
  logic [HASH_W-1:0] i_hmac_digest;
  logic              o_pass_ready, o_hmac_valid, o_hmac_first, o_key_valid, o_busy;
  logic [PASS_W-1:0] o_hmac_key, o_pass;
  logic [SALT_W-1:0] o_hmac_salt;
  logic [HASH_W-1:0] o_hmac_msg, o_key;
  logic [ITER_W-1:0] o_loop;

  always #5 i_clk = ~i_clk;

  pbkdf2_iter_ctrl #(
    .PASS_W(PASS_W), .SALT_W(SALT_W), .HASH_W(HASH_W), .ITER_W(ITER_W),
    .FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_ITER(DEFAULT_ITER)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pass_valid(i_pass_valid), .o_pass_ready(o_pass_ready), .i_pass(i_pass),
    .i_salt(i_salt), .i_iter(i_iter),
    .o_hmac_valid(o_hmac_valid), .i_hmac_ready(i_hmac_ready), .o_hmac_first(o_hmac_first),
    .o_hmac_key(o_hmac_key), .o_hmac_salt(o_hmac_salt), .o_hmac_msg(o_hmac_msg),
    .i_hmac_done(i_hmac_done), .i_hmac_digest(i_hmac_digest),
    .o_key_valid(o_key_valid), .i_key_ready(i_key_ready), .o_key(o_key), .o_pass(o_pass),
    .o_loop(o_loop), .o_busy(o_busy)
  );

  int checks = 0, errors = 0;

  // knobs written by the main process just after posedge, read by the driver at negedge
  bit                rst_knob = 1'b1, hold_done = 1'b0;
  int                hr_mode = 1, kr_mode = 1, lat_max = 0;
  logic [ITER_W-1:0] iter_knob = '0;
  logic [SALT_W-1:0] salt_knob = '0;

  // model: mq[0] is the job in progress, later entries are queued passwords
  logic [PASS_W-1:0] pushq[$];
  logic [PASS_W-1:0] mq[$];
  logic [HASH_W-1:0] digq[$];
  logic [HASH_W-1:0] msgq[$];
  logic [HASH_W-1:0] t_m = '0, u_m = '0;
  int                loop_m = 0, jobs_done = 0, req_cnt = 0, resp_lat = 0;
  bit                resp_pending = 1'b0, resp_stale = 1'b0, expect_kv = 1'b0;

  task automatic chk(input string name, input logic [HASH_W-1:0] act, input logic [HASH_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HASH_W-1:0] rand_hash();
    logic [HASH_W-1:0] r;
    for (int i = 0; i < HASH_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int c_of(input logic [ITER_W-1:0] v);
`ifdef PBKDF2_PIM_EN
    longint c;
    c = (v == '0) ? longint'(DEFAULT_ITER) : 64'd15000 + 64'd1000 * longint'(v);
    if (c > (longint'(1) << ITER_W) - 1) c = (longint'(1) << ITER_W) - 1;
    return int'(c);
`else
    return (v == '0) ? 1 : int'(v);
`endif
  endfunction

  function automatic logic pick(input int mode);
    return (mode == 2) ? logic'($urandom_range(1, 0)) : logic'(mode == 1);
  endfunction

  // Driver, HMAC responder and per-cycle compare, all on the falling edge.
  initial begin
    logic [HASH_W-1:0] d;
    i_rst = 1'b1; i_pass_valid = 1'b0; i_pass = '0; i_salt = '0; i_iter = '0;
    i_hmac_ready = 1'b0; i_hmac_done = 1'b0; i_hmac_digest = '0; i_key_ready = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (expect_kv) begin
          chk("key_valid_latency", HASH_W'(o_key_valid), HASH_W'(1));
          expect_kv = 1'b0;
        end
        if (o_hmac_valid) begin
          chk("req_vs_key_valid", HASH_W'(o_key_valid), '0);
          chk("req_has_job", HASH_W'(mq.size() != 0), HASH_W'(1));
          if (mq.size() != 0) begin
            chk("req_key", HASH_W'(o_hmac_key), HASH_W'(mq[0]));
            chk("req_salt", HASH_W'(o_hmac_salt), HASH_W'(salt_knob));
            chk("req_first", HASH_W'(o_hmac_first), HASH_W'(loop_m == 0));
            chk("req_loop", HASH_W'(o_loop), HASH_W'(loop_m));
            if (loop_m != 0) chk("req_msg", o_hmac_msg, u_m);
          end
        end
        if (o_key_valid) begin
          chk("key_has_job", HASH_W'(mq.size() != 0), HASH_W'(1));
          if (mq.size() != 0) begin
            chk("key_value", o_key, t_m);
            chk("key_pass", HASH_W'(o_pass), HASH_W'(mq[0]));
            chk("key_loop", HASH_W'(o_loop), HASH_W'(c_of(iter_knob)));
          end
        end
      end

      i_rst  = rst_knob;
      i_salt = salt_knob;
      i_iter = iter_knob;
      if (rst_knob) begin
        mq.delete();
        t_m = '0; u_m = '0; loop_m = 0; expect_kv = 1'b0;
        if (resp_pending) resp_stale = 1'b1;
      end

      i_hmac_done = 1'b0;
      if (resp_pending && !hold_done) begin
        if (resp_lat > 0) resp_lat--;
        else begin
          d = (digq.size() != 0) ? digq.pop_front() : rand_hash();
          i_hmac_done = 1'b1;
          i_hmac_digest = d;
          resp_pending = 1'b0;
          if (!resp_stale) begin
            t_m = t_m ^ d;
            u_m = d;
            loop_m++;
            if (loop_m == c_of(iter_knob)) expect_kv = 1'b1;
          end
          resp_stale = 1'b0;
        end
      end

      i_hmac_ready = pick(hr_mode);
      if (!rst_knob && o_hmac_valid && i_hmac_ready) begin
        resp_pending = 1'b1;
        resp_lat = $urandom_range(lat_max, 0);
        req_cnt++;
        msgq.push_back(o_hmac_msg);
      end

      i_key_ready = pick(kr_mode);
      if (!rst_knob && o_key_valid && i_key_ready) begin
        void'(mq.pop_front());
        t_m = '0; u_m = '0; loop_m = 0;
        jobs_done++;
      end

      i_pass_valid = 1'b0;
      if (!rst_knob && pushq.size() != 0) begin
        i_pass_valid = 1'b1;
        i_pass = pushq[0];
        if (o_pass_ready) mq.push_back(pushq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_jobs(input int target, input int bound, input string nm);
    for (int i = 0; i < bound && jobs_done < target; i++) tick();
    chk(nm, HASH_W'(jobs_done >= target), HASH_W'(1));
  endtask

  task automatic wait_kv(input int bound, input string nm);
    for (int i = 0; i < bound && !o_key_valid; i++) tick();
    chk(nm, HASH_W'(o_key_valid), HASH_W'(1));
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, "_pass_ready"}, HASH_W'(o_pass_ready), HASH_W'(1));
    chk({nm, "_hmac_valid"}, HASH_W'(o_hmac_valid), '0);
    chk({nm, "_hmac_first"}, HASH_W'(o_hmac_first), '0);
    chk({nm, "_hmac_key"}, HASH_W'(o_hmac_key), '0);
    chk({nm, "_hmac_salt"}, HASH_W'(o_hmac_salt), '0);
    chk({nm, "_hmac_msg"}, o_hmac_msg, '0);
    chk({nm, "_key_valid"}, HASH_W'(o_key_valid), '0);
    chk({nm, "_key"}, o_key, '0);
    chk({nm, "_pass"}, HASH_W'(o_pass), '0);
    chk({nm, "_loop"}, HASH_W'(o_loop), '0);
    chk({nm, "_busy"}, HASH_W'(o_busy), '0);
  endtask

  initial begin
    logic [PASS_W-1:0] p;
    int base, r0, n;
    salt_knob = SALT_W'(rand_hash());
    repeat (3) tick();
    check_idle_zero("reset");
    rst_knob = 1'b0;
    repeat (2) tick();
    check_idle_zero("post_reset");

`ifdef PBKDF2_PIM_EN
    iter_knob = ITER_W'(1);
    lat_max = 0;
    pushq.push_back(PASS_W'(rand_hash()));
    wait_kv(40000, "pim_timeout");
    chk("pim_loop", HASH_W'(o_loop), HASH_W'(16000));
    wait_jobs(1, 10, "pim_done");
`else
    // single iteration, fixed digest, request timing from FIFO non-empty
    iter_knob = ITER_W'(1);
    kr_mode = 0;
    r0 = req_cnt;
    digq.push_back({64{8'hA5}});
    p = PASS_W'(rand_hash());
    pushq.push_back(p);
    tick();
    chk("t1_valid_c1", HASH_W'(o_hmac_valid), '0);
    tick();
    chk("t1_valid_c2", HASH_W'(o_hmac_valid), '0);
    tick();
    chk("t1_valid_c3", HASH_W'(o_hmac_valid), HASH_W'(1));
    chk("t1_first", HASH_W'(o_hmac_first), HASH_W'(1));
    wait_kv(20, "t1_timeout");
    chk("t1_key", o_key, {64{8'hA5}});
    chk("t1_loop", HASH_W'(o_loop), HASH_W'(1));
    chk("t1_pass", HASH_W'(o_pass), HASH_W'(p));
    chk("t1_reqs", HASH_W'(req_cnt - r0), HASH_W'(1));
    kr_mode = 1;
    wait_jobs(1, 10, "t1_done");

    // three iterations with 1,2,4 then a 10-cycle key stall with another job queued
    iter_knob = ITER_W'(3);
    kr_mode = 0;
    r0 = req_cnt;
    msgq.delete();
    digq.push_back(HASH_W'(1)); digq.push_back(HASH_W'(2)); digq.push_back(HASH_W'(4));
    pushq.push_back(PASS_W'(rand_hash()));
    wait_kv(40, "t2_timeout");
    chk("t2_key", o_key, HASH_W'(7));
    chk("t2_loop", HASH_W'(o_loop), HASH_W'(3));
    chk("t2_reqs", HASH_W'(req_cnt - r0), HASH_W'(3));
    if (msgq.size() >= 3) begin
      chk("t2_msg2", msgq[1], HASH_W'(1));
      chk("t2_msg3", msgq[2], HASH_W'(2));
    end else chk("t2_msgq_len", HASH_W'(msgq.size()), HASH_W'(3));
    pushq.push_back(PASS_W'(rand_hash()));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_key", o_key, HASH_W'(7));
      chk("hold_no_req", HASH_W'(o_hmac_valid), '0);
    end
    kr_mode = 1;
    wait_jobs(3, 60, "t2_done");

    // zero iteration count behaves as one
    iter_knob = '0;
    r0 = req_cnt;
    pushq.push_back(PASS_W'(rand_hash()));
    wait_kv(20, "t0_timeout");
    chk("t0_loop", HASH_W'(o_loop), HASH_W'(1));
    chk("t0_reqs", HASH_W'(req_cnt - r0), HASH_W'(1));
    wait_jobs(4, 10, "t0_done");

    // FIFO fill behind a stalled request
    iter_knob = ITER_W'(2);
    hr_mode = 0;
    pushq.push_back(PASS_W'(rand_hash()));
    for (int i = 0; i < 20 && !o_hmac_valid; i++) tick();
    chk("fifo_stall_req", HASH_W'(o_hmac_valid), HASH_W'(1));
    for (int i = 0; i < 5; i++) pushq.push_back(PASS_W'(rand_hash()));
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("fifo_ready", HASH_W'(o_pass_ready), HASH_W'(k < 4));
    end
    chk("fifo_held_off", HASH_W'(pushq.size()), HASH_W'(1));
    hr_mode = 2; kr_mode = 2; lat_max = 3;
    wait_jobs(10, 400, "fifo_done");

    // randomised rounds
    for (int r = 0; r < 4; r++) begin
      iter_knob = ITER_W'($urandom_range(6, 0));
      salt_knob = SALT_W'(rand_hash());
      n = $urandom_range(8, 3);
      base = jobs_done;
      for (int i = 0; i < n; i++) pushq.push_back(PASS_W'(rand_hash()));
      wait_jobs(base + n, 1500, "rand_done");
    end

    // reset while job 2 waits for its digest, job 3 still queued
    iter_knob = ITER_W'(2);
    hr_mode = 1; kr_mode = 1; lat_max = 1;
    base = jobs_done;
    for (int i = 0; i < 3; i++) pushq.push_back(PASS_W'(rand_hash()));
    wait_jobs(base + 1, 60, "rst_job1");
    hold_done = 1'b1;
    for (int i = 0; i < 20 && !resp_pending; i++) tick();
    chk("rst_in_wait", HASH_W'(resp_pending), HASH_W'(1));
    tick();
    rst_knob = 1'b1;
    repeat (2) tick();
    rst_knob = 1'b0;
    hold_done = 1'b0;
    repeat (3) tick();
    chk("rst_done_sent", HASH_W'(resp_pending), '0);
    check_idle_zero("rst_mid_job");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_stays_idle", HASH_W'(o_busy), '0);
    end

    // recovery
    base = jobs_done;
    iter_knob = ITER_W'(3);
    pushq.push_back(PASS_W'(rand_hash()));
    wait_jobs(base + 1, 60, "recover_done");
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pbkdf2_iter_ctrl.md
Name: pbkdf2_iter_ctrl

Overview:
Parametrised PBKDF2 outer-loop controller. It queues candidate passwords in an input FIFO and drives an external HMAC core through a valid/ready request and done-pulse return. It XOR-accumulates U1..Uc into T, counts iterations against a per-job iteration count, and presents {key, password} on a valid/ready output. It generalises the fixed single-password PBKDF2-HMAC-Whirlpool top with parametrised widths and depth, a runtime iteration count, buffering and output backpressure.

Parameters:
PASS_W, 192, password width in bits
SALT_W, 512, salt width in bits
HASH_W, 512, HMAC digest / derived key width
ITER_W, 19, iteration counter width
FIFO_DEPTH, 4, password FIFO entries (power of 2, >=2)
DEFAULT_ITER, 500000, iteration count used when i_iter==0 in PIM mode

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_pass_valid  in  1  password push request
o_pass_ready  out  1  FIFO not full
i_pass  in  PASS_W  password
i_salt  in  SALT_W  salt; static, sampled at job start
i_iter  in  ITER_W  iteration count (PIM value when PIM_EN); sampled at job start
o_hmac_valid  out  1  HMAC request
i_hmac_ready  in  1  HMAC core accepts request
o_hmac_first  out  1  1: message is salt||INT(1); 0: message is o_hmac_msg
o_hmac_key  out  PASS_W  HMAC key (current password)
o_hmac_salt  out  SALT_W  latched salt
o_hmac_msg  out  HASH_W  previous U
i_hmac_done  in  1  one-cycle digest-valid pulse
i_hmac_digest  in  HASH_W  digest
o_key_valid  out  1  derived key available
i_key_ready  in  1  consumer accepts key
o_key  out  HASH_W  T
o_pass  out  PASS_W  password that produced o_key
o_loop  out  ITER_W  completed iterations of current job
o_busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, any time, including mid-job): FIFO empty, FSM IDLE. All outputs 0 except o_pass_ready=1. In-flight HMAC result discarded; a done pulse after reset release is ignored in IDLE.
- FIFO: push when i_pass_valid&&o_pass_ready. o_pass_ready = !full, registered. On full with simultaneous pop, the push is refused; ready rises the next cycle. Pointers wrap mod FIFO_DEPTH.
- FSM IDLE -> LOAD when FIFO non-empty. LOAD, 1 cycle: pop the password; latch salt and c; T=0; o_loop=0 -> ISSUE.
- ISSUE: o_hmac_valid=1, o_hmac_first=(o_loop==0). Payload is stable while valid. On i_hmac_ready -> WAIT. Request valid appears 2 cycles after the FIFO becomes non-empty in IDLE.
- WAIT: on i_hmac_done: T^=digest; U=digest; o_loop+=1. If o_loop+1==c -> OUT, else -> ISSUE. The done pulse is ignored in every other state.
- OUT: o_key_valid=1, o_key=T, o_pass=latched password, all held stable. On i_key_ready -> IDLE, or directly to LOAD if the FIFO is non-empty. o_loop holds c until the next LOAD.
- c==0 is treated as 1.
- Latency from final done to o_key_valid: 1 cycle.
- The FIFO accepts pushes during any state.

Optional Feature:
PBKDF2_PIM_EN
- Defined: i_iter is a PIM value. c = 15000 + 1000*PIM when PIM!=0; c = DEFAULT_ITER when PIM==0; c saturates at 2^ITER_W-1. The multiply is registered in LOAD, adding 1 cycle to LOAD.
- Undefined: i_iter is the raw iteration count (0 -> 1).

Test Plan:
- i_iter=1, HMAC model returns D1=512'hA5..A5 -> one request with first=1; o_key=D1; o_loop=1; o_key_valid 1 cycle after done.
- i_iter=3, digests D1=1, D2=2, D3=4 -> second and third requests have first=0, msg=D1 then D2; o_key=7; o_loop=3.
- Push 5 passwords back-to-back while HMAC ready held 0 -> first 4 accepted; ready drops after the 4th push; 5th held off; keys emerge in push order with matching o_pass.
- i_key_ready=0 for 10 cycles at OUT -> o_key/o_pass stable; no new HMAC request; the next job starts after the ready handshake.
- Assert i_rst during WAIT of job 2, then send done -> all outputs zero, FIFO empty, done ignored, o_pass_ready=1.
- i_iter=0 -> single iteration; with PBKDF2_PIM_EN, i_iter=485 -> o_loop reaches 500000 (HMAC model zero-latency).
